// File: rtl/serial_cmp.sv
// Digit-serial magnitude comparator: evaluates I0 - I1 one DIGIT-bit slice per cycle, LSB first.
// Optional FLAGS output {N,V,C,Z} is enabled by defining MANTLE_CMP_FLAGS_EN.
module serial_cmp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [2:0]       OP,
  input  logic             VALID_IN,
  output logic             READY_IN,
  output logic             O,
  output logic             VALID_OUT,
  input  logic             READY_OUT
`ifdef MANTLE_CMP_FLAGS_EN
  ,
  output logic [3:0]       FLAGS
`endif
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic mode_result(input logic [2:0] op, input logic n, input logic v,
                                       input logic c, input logic z);
    logic r;
    case (op)
      3'd0:    r = z;
      3'd1:    r = ~z;
      3'd2:    r = ~c;
      3'd3:    r = ~c | z;
      3'd4:    r = c & ~z;
      3'd5:    r = c;
      3'd6:    r = n ^ v;
      3'd7:    r = (n ^ v) | z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic             carry_r;
  logic             eq_r;
  logic [CW-1:0]    cnt_r;
  logic             ready_r;
  logic             valid_r;
  logic             o_r;
`ifdef MANTLE_CMP_FLAGS_EN
  logic [3:0]       flags_r;
`endif

  logic [DIGIT-1:0] a_d_s;
  logic [DIGIT-1:0] b_d_s;
  logic [DIGIT:0]   sum_s;
  logic             c_s;
  logic             z_s;
  logic             n_s;
  logic             v_s;
  logic             last_s;

  // One slice of the subtract chain plus the flags it would produce if it were the top digit
  always_comb begin
    a_d_s  = a_r[DIGIT-1:0];
    b_d_s  = b_r[DIGIT-1:0];
    sum_s  = {1'b0, a_d_s} + {1'b0, ~b_d_s} + {{DIGIT{1'b0}}, carry_r};
    c_s    = sum_s[DIGIT];
    z_s    = eq_r & (a_d_s == b_d_s);
    n_s    = sum_s[DIGIT-1];
    v_s    = (a_d_s[DIGIT-1] != b_d_s[DIGIT-1]) & (n_s != a_d_s[DIGIT-1]);
    last_s = (cnt_r == CW'(K - 1));
  end

  // Control FSM and datapath registers; handshake outputs are registered alongside the state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= 3'd0;
      carry_r <= 1'b0;
      eq_r    <= 1'b0;
      cnt_r   <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      o_r     <= 1'b0;
`ifdef MANTLE_CMP_FLAGS_EN
      flags_r <= 4'b0000;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (VALID_IN && ready_r) begin
            a_r     <= I0;
            b_r     <= I1;
            op_r    <= OP;
            carry_r <= 1'b1;
            eq_r    <= 1'b1;
            cnt_r   <= '0;
            ready_r <= 1'b0;
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          carry_r <= c_s;
          eq_r    <= z_s;
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            o_r     <= mode_result(op_r, n_s, v_s, c_s, z_s);
`ifdef MANTLE_CMP_FLAGS_EN
            flags_r <= {n_s, v_s, c_s, z_s};
`endif
            valid_r <= 1'b1;
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          if (READY_OUT) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign READY_IN  = ready_r;
  assign VALID_OUT = valid_r;
  assign O         = o_r;
`ifdef MANTLE_CMP_FLAGS_EN
  assign FLAGS     = flags_r;
`endif

endmodule

// File: tb/tb_serial_cmp.sv
// Scoreboard bench for serial_cmp (WIDTH=16, DIGIT=4) with hand-computed expected results.
module tb_serial_cmp;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] I0;
  logic [15:0] I1;
  logic [2:0]  OP;
  logic        VALID_IN;
  logic        READY_OUT;
  logic        READY_IN;
  logic        O;
  logic        VALID_OUT;
`ifdef MANTLE_CMP_FLAGS_EN
  logic [3:0]  FLAGS;
`endif

  serial_cmp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .I0(I0),
    .I1(I1),
    .OP(OP),
    .VALID_IN(VALID_IN),
    .READY_IN(READY_IN),
    .O(O),
    .VALID_OUT(VALID_OUT),
    .READY_OUT(READY_OUT)
`ifdef MANTLE_CMP_FLAGS_EN
    ,
    .FLAGS(FLAGS)
`endif
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];  // {flags, o}

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        o;
    logic [3:0]  f;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected entry per output transfer
  always @(negedge CLK) begin
    if (RESET === 1'b0 && VALID_OUT === 1'b1 && READY_OUT === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("O", {31'd0, O}, {31'd0, e[0]});
`ifdef MANTLE_CMP_FLAGS_EN
        check("FLAGS", {28'd0, FLAGS}, {28'd0, e[4:1]});
`endif
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic o, input logic [3:0] f, input bit push);
    int n = 0;
    while (READY_IN !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) check("ready_in_timeout", 32'd0, 32'd1);
    I0 = a; I1 = b; OP = op; VALID_IN = 1'b1;
    if (push) exp_q.push_back({f, o});
    @(posedge CLK); #1;
    VALID_IN = 1'b0;
    I0 = ~a; I1 = ~b; OP = ~op;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (VALID_OUT !== 1'b1 && n < 30) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 30) check("valid_out_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    RESET = 1'b1; VALID_IN = 1'b0; READY_OUT = 1'b1;
    I0 = 16'h0000; I1 = 16'h0000; OP = 3'd0;
    #12;
    check("reset_ready_in", {31'd0, READY_IN}, 32'd1);
    check("reset_valid_out", {31'd0, VALID_OUT}, 32'd0);
    check("reset_o", {31'd0, O}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // ULE 3 <= 5: latency and handshake return
    send(3'd3, 16'h0003, 16'h0005, 1'b1, 4'b1000, 1'b1);
    wait_valid(n);
    check("latency_edges", n, 32'd4);
    @(posedge CLK); #1;
    check("valid_drop", {31'd0, VALID_OUT}, 32'd0);
    check("ready_back", {31'd0, READY_IN}, 32'd1);

    vecs.push_back('{3'd3, 16'hFFFF, 16'hFFFF, 1'b1, 4'b0011});
    vecs.push_back('{3'd2, 16'hFFFF, 16'hFFFF, 1'b0, 4'b0011});
    vecs.push_back('{3'd0, 16'hFFFF, 16'hFFFF, 1'b1, 4'b0011});
    vecs.push_back('{3'd1, 16'hFFFF, 16'hFFFF, 1'b0, 4'b0011});
    vecs.push_back('{3'd6, 16'h8000, 16'h0001, 1'b1, 4'b0110});
    vecs.push_back('{3'd2, 16'h8000, 16'h0001, 1'b0, 4'b0110});
    vecs.push_back('{3'd4, 16'h8000, 16'h0001, 1'b1, 4'b0110});
    vecs.push_back('{3'd6, 16'h7FFF, 16'h8000, 1'b0, 4'b1100});
    vecs.push_back('{3'd2, 16'h7FFF, 16'h8000, 1'b1, 4'b1100});
    vecs.push_back('{3'd5, 16'h0005, 16'h0003, 1'b1, 4'b0010});
    vecs.push_back('{3'd7, 16'hFFFF, 16'h0001, 1'b1, 4'b1010});
    vecs.push_back('{3'd7, 16'h0002, 16'hFFFE, 1'b0, 4'b0000});
    vecs.push_back('{3'd1, 16'h1234, 16'h1235, 1'b1, 4'b1000});
    vecs.push_back('{3'd4, 16'h0000, 16'h0000, 1'b0, 4'b0011});
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].f, 1'b1);
      wait_valid(n);
    end

    // Backpressure in DONE with a competing VALID_IN
    @(posedge CLK); #1;
    READY_OUT = 1'b0;
    send(3'd2, 16'h0001, 16'h0002, 1'b1, 4'b1000, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 3; i++) begin
      I0 = 16'h0005; I1 = 16'h0001; OP = 3'd4; VALID_IN = 1'b1;
      check("bp_valid_out", {31'd0, VALID_OUT}, 32'd1);
      check("bp_o", {31'd0, O}, 32'd1);
      check("bp_ready_in", {31'd0, READY_IN}, 32'd0);
      @(posedge CLK); #1;
    end
    VALID_IN = 1'b0;
    check("bp_valid_hold", {31'd0, VALID_OUT}, 32'd1);
    READY_OUT = 1'b1;
    send(3'd4, 16'h0005, 16'h0001, 1'b1, 4'b0010, 1'b1);
    wait_valid(n);

    // Asynchronous reset after two RUN edges discards the operation
    send(3'd5, 16'h0000, 16'hFFFF, 1'b0, 4'b0000, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2 RESET = 1'b1;
    #1;
    check("async_ready_in", {31'd0, READY_IN}, 32'd1);
    check("async_valid_out", {31'd0, VALID_OUT}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("post_reset_idle", {31'd0, VALID_OUT}, 32'd0);
    end
    send(3'd5, 16'h1234, 16'h1233, 1'b1, 4'b0010, 1'b1);
    wait_valid(n);
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
